// File: rtl/bus_memory_slave_if.sv
// Single-master burst bus as seen by a word-organised memory responder.
interface bus_memory_slave_if;
  logic        begin_transaction;
  logic [31:0] address_data;
  logic        read_not_write;
  logic [7:0]  burst_size;
  logic [3:0]  byte_enables;
  logic        data_valid;
  logic        end_transaction;
  logic [31:0] resp_data;
  logic        resp_valid;
  logic        resp_end;
  logic        bus_error;
  logic        busy;

  modport master (
    output begin_transaction, address_data, read_not_write, burst_size,
           byte_enables, data_valid, end_transaction,
    input  resp_data, resp_valid, resp_end, bus_error, busy
  );

  modport slave (
    input  begin_transaction, address_data, read_not_write, burst_size,
           byte_enables, data_valid, end_transaction,
    output resp_data, resp_valid, resp_end, bus_error, busy
  );
endinterface

// File: rtl/bus_memory_slave.sv
// Burst-bus memory responder: decodes a 2^ADDRESS_BITS word region, serves
// burst reads/writes with lane masks, optional write stalls and error replies.
module bus_memory_slave #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int unsigned ADDRESS_BITS = 9,
  parameter int unsigned STALL_EVERY  = 0
) (
  input logic              clock,
  input logic              reset,
  bus_memory_slave_if.slave bus
);
  localparam int unsigned DEPTH   = 1 << ADDRESS_BITS;
  localparam int unsigned TAG_LSB = ADDRESS_BITS + 2;

  typedef enum logic [2:0] {IDLE, READ, READ_END, WRITE, ERROR} state_t;

  state_t                  state, state_d;
  logic [ADDRESS_BITS-1:0] index, index_d;
  logic [8:0]              beats, beats_d;
  logic [7:0]              last, last_d;
  logic [3:0]              lanes, lanes_d;
  logic [31:0]             stall_cnt, stall_cnt_d;
  logic                    rd_en, wr_en, end_d, err_d, busy_d;

  logic [31:0] mem [DEPTH];

  // Address decode; 33-bit end address so a burst can never wrap into the region
  logic [32:0] end_ext;
  logic        hit, legal;
  assign end_ext = {1'b0, bus.address_data} + {23'b0, bus.burst_size, 2'b00} + 33'd3;
  assign hit     = bus.address_data[31:TAG_LSB] == BASE_ADDRESS[31:TAG_LSB];
  assign legal   = hit && (bus.address_data[1:0] == 2'b00) &&
                   (end_ext[32:TAG_LSB] == {1'b0, BASE_ADDRESS[31:TAG_LSB]});

  always_comb begin
    state_d     = state;
    index_d     = index;
    beats_d     = beats;
    last_d      = last;
    lanes_d     = lanes;
    stall_cnt_d = stall_cnt;
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    end_d       = 1'b0;
    err_d       = 1'b0;
    busy_d      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.begin_transaction && hit) begin
          index_d     = bus.address_data[TAG_LSB-1:2];
          beats_d     = '0;
          last_d      = bus.burst_size;
          lanes_d     = bus.byte_enables;
          stall_cnt_d = '0;
          if (!legal)                  state_d = ERROR;
          else if (bus.read_not_write) state_d = READ;
          else                         state_d = WRITE;
        end
      end
      READ: begin
        // An abort suppresses the beat that would otherwise be issued this cycle
        if (bus.end_transaction) begin
          state_d = IDLE;
        end else begin
          rd_en   = 1'b1;
          index_d = index + ADDRESS_BITS'(1);
          beats_d = beats + 9'd1;
          if (beats[7:0] == last) state_d = READ_END;
        end
      end
      READ_END: begin
        end_d   = 1'b1;
        state_d = IDLE;
      end
      WRITE: begin
        if (bus.data_valid && !bus.busy && (beats <= {1'b0, last})) begin
          wr_en   = 1'b1;
          index_d = index + ADDRESS_BITS'(1);
          beats_d = beats + 9'd1;
          if (STALL_EVERY != 0) begin
            if (stall_cnt == 32'(STALL_EVERY - 1)) begin
              stall_cnt_d = '0;
              busy_d      = !bus.end_transaction;
            end else begin
              stall_cnt_d = stall_cnt + 32'd1;
            end
          end
        end
        if (bus.end_transaction) state_d = IDLE;
      end
      ERROR: begin
        end_d   = 1'b1;
        err_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= IDLE;
      index          <= '0;
      beats          <= '0;
      last           <= '0;
      lanes          <= '0;
      stall_cnt      <= '0;
      bus.resp_data  <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_end   <= 1'b0;
      bus.bus_error  <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      state          <= state_d;
      index          <= index_d;
      beats          <= beats_d;
      last           <= last_d;
      lanes          <= lanes_d;
      stall_cnt      <= stall_cnt_d;
      bus.resp_data  <= rd_en ? mem[index] : '0;
      bus.resp_valid <= rd_en;
      bus.resp_end   <= end_d;
      bus.bus_error  <= err_d;
      bus.busy       <= busy_d;
    end
  end

  // Storage is never reset; per-byte write enables from the latched lane mask
  always_ff @(posedge clock) begin
    if (wr_en && reset) begin
      for (int i = 0; i < 4; i++) begin
        if (lanes[i]) mem[index][8*i +: 8] <= bus.address_data[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_bus_memory_slave.sv
// Bench for bus_memory_slave: vector table, hand sequences and random traffic
// checked against a cycle-level reference model of the bus protocol.
module tb_bus_memory_slave;
  localparam logic [31:0] BASE_A = 32'h2000_0800;
  localparam logic [31:0] BASE_B = 32'h0000_0000;
  localparam int K_OK = 0;
  localparam int K_ERR = 1;
  localparam int K_MISS = 2;
  localparam int NV = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  bus_memory_slave_if ifa ();
  bus_memory_slave_if ifb ();

  bus_memory_slave #(.BASE_ADDRESS(BASE_A), .ADDRESS_BITS(9), .STALL_EVERY(0)) dut_a (
    .clock(clock), .reset(reset), .bus(ifa));
  bus_memory_slave #(.BASE_ADDRESS(BASE_B), .ADDRESS_BITS(9), .STALL_EVERY(2)) dut_b (
    .clock(clock), .reset(reset), .bus(ifb));

  int          sel;
  logic        m_begin, m_rnw, m_dv, m_end;
  logic [31:0] m_ad;
  logic [7:0]  m_burst;
  logic [3:0]  m_be;

  assign ifa.begin_transaction = (sel == 0) && m_begin;
  assign ifa.address_data      = (sel == 0) ? m_ad : 32'h0;
  assign ifa.read_not_write    = (sel == 0) && m_rnw;
  assign ifa.burst_size        = (sel == 0) ? m_burst : 8'h0;
  assign ifa.byte_enables      = (sel == 0) ? m_be : 4'h0;
  assign ifa.data_valid        = (sel == 0) && m_dv;
  assign ifa.end_transaction   = (sel == 0) && m_end;
  assign ifb.begin_transaction = (sel == 1) && m_begin;
  assign ifb.address_data      = (sel == 1) ? m_ad : 32'h0;
  assign ifb.read_not_write    = (sel == 1) && m_rnw;
  assign ifb.burst_size        = (sel == 1) ? m_burst : 8'h0;
  assign ifb.byte_enables      = (sel == 1) ? m_be : 4'h0;
  assign ifb.data_valid        = (sel == 1) && m_dv;
  assign ifb.end_transaction   = (sel == 1) && m_end;

  logic [35:0] obs;
  assign obs = (sel == 0) ? {ifa.resp_data, ifa.resp_valid, ifa.resp_end, ifa.bus_error, ifa.busy}
                          : {ifb.resp_data, ifb.resp_valid, ifb.resp_end, ifb.bus_error, ifb.busy};

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mm [2][512];
  logic [31:0] wbuf [300];

  typedef struct {
    logic        rnw;
    int          offset;
    logic [7:0]  burst;
    logic [3:0]  be;
    int          nbeats;
    logic        end_last;
    int          kind;
    logic [31:0] d0;
    logic [31:0] step;
  } vec_t;
  vec_t vt [NV];

  int hs_dat [7];
  logic hs_dv [7];
  logic hs_busy [7];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] base_of(input int s);
    return (s == 0) ? BASE_A : BASE_B;
  endfunction

  function automatic int stall_of(input int s);
    return (s == 0) ? 0 : 2;
  endfunction

  function automatic logic [35:0] pk(input logic [31:0] d, input logic v, input logic e,
                                     input logic er, input logic b);
    return {d, v, e, er, b};
  endfunction

  // Region membership and legality by plain address arithmetic
  function automatic int classify(input logic [31:0] base, input logic [31:0] addr,
                                  input logic [7:0] b);
    longint unsigned lo, hi, a, e;
    lo = 64'(base);
    hi = lo + 64'd2047;
    a  = 64'(addr);
    e  = a + 64'd4 * 64'(b) + 64'd3;
    if (a < lo || a > hi) return K_MISS;
    if ((a % 64'd4) != 64'd0 || e > hi) return K_ERR;
    return K_OK;
  endfunction

  task automatic check(input string name, input logic [35:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got data=%h v/e/err/busy=%b want data=%h v/e/err/busy=%b",
               name, obs[35:4], obs[3:0], want[35:4], want[3:0]);
    end
  endtask

  task automatic idle_master();
    m_begin = 1'b0; m_ad = 32'h0; m_rnw = 1'b0; m_burst = 8'h0;
    m_be = 4'h0; m_dv = 1'b0; m_end = 1'b0;
  endtask

  task automatic do_read(input int s, input int offset, input logic [7:0] b,
                         input int kind, input string name);
    int          idx;
    logic [35:0] want;
    sel = s;
    idx = (offset >>> 2) & 511;
    m_begin = 1'b1; m_ad = base_of(s) + 32'(offset); m_rnw = 1'b1; m_burst = b; m_be = 4'hF;
    tick();
    idle_master();
    for (int c = 1; c <= int'(b) + 4; c++) begin
      want = '0;
      if (kind == K_ERR && c == 2) want = pk(32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
      if (kind == K_OK && c >= 2 && c <= int'(b) + 2) want = pk(mm[s][idx + c - 2], 1'b1, 1'b0, 1'b0, 1'b0);
      if (kind == K_OK && c == int'(b) + 3) want = pk(32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      check(name, want);
      tick();
    end
  endtask

  // Master sends nbeats from wbuf, holding data while the slave is expected busy
  task automatic do_write(input int s, input int offset, input logic [7:0] b, input logic [3:0] be,
                          input int nbeats, input logic end_last, input int kind, input string name);
    int   idx, sent, stored, cnt, c;
    logic busy_e, busy_n, ended;
    sel = s;
    idx = (offset >>> 2) & 511;
    m_begin = 1'b1; m_ad = base_of(s) + 32'(offset); m_rnw = 1'b0; m_burst = b; m_be = be;
    tick();
    idle_master();
    sent = 0; stored = 0; cnt = 0; c = 1; busy_e = 1'b0; ended = 1'b0;
    while (!ended && c < 1000) begin
      m_dv  = (sent < nbeats);
      m_ad  = m_dv ? wbuf[sent] : 32'h0;
      m_end = (sent >= nbeats) || (end_last && sent == nbeats - 1);
      check(name, (kind == K_ERR && c == 2) ? pk(32'h0, 1'b0, 1'b1, 1'b1, 1'b0)
                                            : pk(32'h0, 1'b0, 1'b0, 1'b0, busy_e));
      busy_n = 1'b0;
      if (m_dv && !busy_e) begin
        if (kind == K_OK && stored <= int'(b)) begin
          for (int l = 0; l < 4; l++)
            if (be[l]) mm[s][idx + stored][8*l +: 8] = m_ad[8*l +: 8];
          stored++;
          if (stall_of(s) > 0) begin
            cnt++;
            if (cnt == stall_of(s)) begin
              cnt = 0;
              busy_n = !m_end;
            end
          end
        end
        sent++;
      end
      busy_e = busy_n;
      ended  = m_end;
      tick();
      c++;
    end
    if (!ended) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: write did not complete within cycle budget", name);
    end
    idle_master();
    for (int k = 0; k < 2; k++) begin
      check(name, (kind == K_ERR && c == 2) ? pk(32'h0, 1'b0, 1'b1, 1'b1, 1'b0) : 36'h0);
      tick();
      c++;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int          s, off, nb, kind;
    logic [7:0]  b;

    vt[0]  = '{1'b0, 0,        8'd3,   4'hF, 4, 1'b1, K_OK,   32'h1111_1111, 32'h1111_1111};
    vt[1]  = '{1'b1, 0,        8'd3,   4'hF, 0, 1'b0, K_OK,   32'h0, 32'h0};
    vt[2]  = '{1'b0, 8,        8'd1,   4'hF, 2, 1'b1, K_OK,   32'h0, 32'h0};
    vt[3]  = '{1'b0, 8,        8'd1,   4'h3, 2, 1'b1, K_OK,   32'hAABB_CCDD, 32'h6778_899B};
    vt[4]  = '{1'b1, 8,        8'd1,   4'hF, 0, 1'b0, K_OK,   32'h0, 32'h0};
    vt[5]  = '{1'b1, 4*510,    8'd3,   4'hF, 0, 1'b0, K_ERR,  32'h0, 32'h0};
    vt[6]  = '{1'b1, 2,        8'd0,   4'hF, 0, 1'b0, K_ERR,  32'h0, 32'h0};
    vt[7]  = '{1'b1, -4,       8'd0,   4'hF, 0, 1'b0, K_MISS, 32'h0, 32'h0};
    vt[8]  = '{1'b1, 2048,     8'd3,   4'hF, 0, 1'b0, K_MISS, 32'h0, 32'h0};
    vt[9]  = '{1'b1, 4*508,    8'd3,   4'hF, 0, 1'b0, K_OK,   32'h0, 32'h0};
    vt[10] = '{1'b0, 4*511,    8'd1,   4'hF, 2, 1'b1, K_ERR,  32'hDEAD_BEEF, 32'h1};
    vt[11] = '{1'b1, 4*511,    8'd0,   4'hF, 0, 1'b0, K_OK,   32'h0, 32'h0};
    vt[12] = '{1'b0, 16,       8'd1,   4'hF, 4, 1'b0, K_OK,   32'hA000_0001, 32'h1};
    vt[13] = '{1'b1, 16,       8'd3,   4'hF, 0, 1'b0, K_OK,   32'h0, 32'h0};
    vt[14] = '{1'b1, 4*256,    8'd255, 4'hF, 0, 1'b0, K_OK,   32'h0, 32'h0};
    vt[15] = '{1'b1, 4*257,    8'd255, 4'hF, 0, 1'b0, K_ERR,  32'h0, 32'h0};

    hs_dat  = '{0, 1, 2, 2, 3, 0, 0};
    hs_dv   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    hs_busy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    sel = 0;
    idle_master();
    reset = 1'b0;
    repeat (3) tick();
    check("reset_a", 36'h0);
    sel = 1;
    check("reset_b", 36'h0);
    reset = 1'b1;
    tick();

    // Fill both memories so every later read has a known value
    for (int sx = 0; sx < 2; sx++)
      for (int h = 0; h < 2; h++) begin
        for (int k = 0; k < 256; k++) wbuf[k] = $urandom;
        do_write(sx, h * 1024, 8'd255, 4'hF, 256, 1'b1, K_OK, "preload");
      end

    for (int i = 0; i < NV; i++) begin
      if (vt[i].rnw) begin
        do_read(0, vt[i].offset, vt[i].burst, vt[i].kind, $sformatf("vec%0d_rd", i));
      end else begin
        for (int k = 0; k < vt[i].nbeats; k++) wbuf[k] = vt[i].d0 + 32'(k) * vt[i].step;
        do_write(0, vt[i].offset, vt[i].burst, vt[i].be, vt[i].nbeats, vt[i].end_last,
                 vt[i].kind, $sformatf("vec%0d_wr", i));
      end
    end

    // Stall every 2 beats: data held across the busy cycle lands exactly once
    sel = 1;
    for (int k = 0; k < 4; k++) wbuf[k] = 32'hC0DE_0000 + 32'(k);
    m_begin = 1'b1; m_ad = BASE_B + 32'h40; m_rnw = 1'b0; m_burst = 8'd3; m_be = 4'hF;
    tick();
    idle_master();
    for (int c = 0; c < 7; c++) begin
      m_dv  = hs_dv[c];
      m_ad  = hs_dv[c] ? wbuf[hs_dat[c]] : 32'h0;
      m_end = (c == 5);
      check($sformatf("stall_busy_c%0d", c + 1), pk(32'h0, 1'b0, 1'b0, 1'b0, hs_busy[c]));
      tick();
    end
    idle_master();
    for (int k = 0; k < 4; k++) mm[1][16 + k] = wbuf[k];
    do_read(1, 32'h40, 8'd3, K_OK, "stall_readback");

    // Abort an 8-beat read after its third beat
    sel = 0;
    m_begin = 1'b1; m_ad = BASE_A + 32'h20; m_rnw = 1'b1; m_burst = 8'd7; m_be = 4'hF;
    tick();
    idle_master();
    check("abort_t1", 36'h0);
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("abort_beat%0d", k), pk(mm[0][8 + k], 1'b1, 1'b0, 1'b0, 1'b0));
      if (k == 2) m_end = 1'b1;
      tick();
    end
    m_end = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check("abort_quiet", 36'h0);
      tick();
    end

    // Reset during the second beat of an 8-beat read
    m_begin = 1'b1; m_ad = BASE_A; m_rnw = 1'b1; m_burst = 8'd7; m_be = 4'hF;
    tick();
    idle_master();
    check("rst_t1", 36'h0);
    tick();
    check("rst_beat0", pk(mm[0][0], 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    check("rst_beat1", pk(mm[0][1], 1'b1, 1'b0, 1'b0, 1'b0));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("rst_quiet", 36'h0);
      tick();
    end
    do_read(0, 12, 8'd0, K_OK, "post_rst_rd");

    // Random traffic on both slaves
    for (int i = 0; i < 60; i++) begin
      s = int'($urandom_range(0, 1));
      b = 8'($urandom_range(0, 12));
      case ($urandom_range(0, 9))
        0: off = 4 * int'($urandom_range(0, 511)) + int'($urandom_range(1, 3));
        1: off = 2048 + 4 * int'($urandom_range(0, 100));
        2: off = -4 * int'($urandom_range(1, 100));
        3: off = 4 * (512 - int'($urandom_range(1, 10)));
        default: off = 4 * int'($urandom_range(0, 511));
      endcase
      kind = classify(base_of(s), base_of(s) + 32'(off), b);
      if ($urandom_range(0, 1) == 1) begin
        do_read(s, off, b, kind, $sformatf("rnd%0d_rd", i));
      end else begin
        nb = int'($urandom_range(1, int'(b) + 3));
        for (int k = 0; k < nb; k++) wbuf[k] = $urandom;
        do_write(s, off, b, 4'($urandom_range(1, 15)), nb, 1'($urandom_range(0, 1)), kind,
                 $sformatf("rnd%0d_wr", i));
      end
    end

    // Sweep every word of both memories against the model
    for (int sx = 0; sx < 2; sx++)
      for (int h = 0; h < 2; h++)
        do_read(sx, h * 1024, 8'd255, K_OK, "final_sweep");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
